// File: rtl/sramx_bus_arbiter_pkg.sv
// Shared types for the SRAMx bus arbiter and the SRAMx converters.
package sramx_bus_arbiter_pkg;

  // Counter width; STARVE_LIMIT must fit (1..15).
  localparam int STARVE_CNT_W = 4;

  // Owner of the response due in the cycle after issue.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } arb_state_t;

  // One memory-port request. An idle port is the all-zero value.
  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sramx_bus_arbiter_if.sv
// Fetch channel, data channel and unified memory port.
// Handshake: a requester raises valid with stable fields and holds both until
// addr_ok; addr_ok is combinational in the accept cycle, and data_ok with
// rdata comes exactly one cycle later. rdata is 0 whenever data_ok is 0.
interface sramx_bus_arbiter_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [3:0]  d_wen;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Requester/memory side: drives requests and memory read data.
  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wen, d_wdata, mem_rdata,
    input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wen, d_wdata, mem_rdata,
    output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sramx_starve_counter.sv
// Counts consecutive cycles a pending fetch has been denied; raises urgent at
// the limit so the fetch overrides data priority.
module sramx_starve_counter
  import sramx_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_valid,
  input  logic                    grant_i,
  output logic                    urgent,
  output logic [STARVE_CNT_W-1:0] cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("sramx_starve_counter: STARVE_LIMIT must be in 1..15");
  end

  // Clear on a fetch grant or no fetch pending; otherwise count up to LIMIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (grant_i || !i_valid) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fetch has waited long enough to win over data.
  always_comb begin
    urgent = (cnt == LIMIT);
  end

endmodule

// File: rtl/sramx_bus_arbiter.sv
// Per-cycle arbiter sharing one SRAMx port between fetch and data channels.
// Data wins by default; a starvation counter forces a fetch grant after
// STARVE_LIMIT denied cycles. One access per cycle, response one cycle later.
module sramx_bus_arbiter
  import sramx_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  sramx_bus_arbiter_if.slave      bus,
  output arb_state_t              dbg_state,
  output logic [STARVE_CNT_W-1:0] dbg_starve_cnt
);

  logic       urgent;
  logic       grant_i;
  logic       grant_d;
  mem_req_t   req;
  arb_state_t state;
  arb_state_t state_next;

  sramx_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (bus.i_valid),
    .grant_i (grant_i),
    .urgent  (urgent),
    .cnt     (dbg_starve_cnt)
  );

  // Grant and the winner's request; fetches never write.
  always_comb begin
    grant_i = bus.i_valid & (~bus.d_valid | urgent);
    grant_d = bus.d_valid & ~grant_i;
    req     = '0;
    if (grant_i) begin
      req.en   = 1'b1;
      req.addr = bus.i_addr;
    end else if (grant_d) begin
      req.en    = 1'b1;
      req.wen   = bus.d_wen;
      req.addr  = bus.d_addr;
      req.wdata = bus.d_wdata;
    end
  end

  // State register: owner of the response due next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state from the grant, evaluated in every state for back-to-back issue.
  always_comb begin
    state_next = IDLE;
    if (grant_i) begin
      state_next = RESP_I;
    end else if (grant_d) begin
      state_next = RESP_D;
    end
  end

  // Outputs: issue side from the grant, response side from the state;
  // everything forced to 0 while reset is asserted.
  always_comb begin
    bus.i_addr_ok = 1'b0;
    bus.i_data_ok = 1'b0;
    bus.i_rdata   = '0;
    bus.d_addr_ok = 1'b0;
    bus.d_data_ok = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_wen   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (resetn) begin
      bus.i_addr_ok = grant_i;
      bus.d_addr_ok = grant_d;
      bus.mem_en    = req.en;
      bus.mem_wen   = req.wen;
      bus.mem_addr  = req.addr;
      bus.mem_wdata = req.wdata;
      case (state)
        RESP_I: begin
          bus.i_data_ok = 1'b1;
          bus.i_rdata   = bus.mem_rdata;
        end
        RESP_D: begin
          bus.d_data_ok = 1'b1;
          bus.d_rdata   = bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Debug view of the FSM.
  always_comb begin
    dbg_state = state;
  end

endmodule
